// File: rtl/gray_conv_arbiter_if.sv
// Request and result channels between Gray-code requesters and the shared converter arbiter.
// Both channels use valid/ready: a transfer happens in any cycle where valid and ready are both high.
interface gray_conv_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_gray;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_bin;
    logic [ID_W-1:0]        out_id;

    modport master (
        output req_valid, req_gray, out_ready,
        input  req_ready, out_valid, out_bin, out_id
    );

    modport slave (
        input  req_valid, req_gray, out_ready,
        output req_ready, out_valid, out_bin, out_id
    );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin sequencer that time-shares one combinational Gray->binary converter
// among N_REQ requesters; one conversion per grant, result returned with requester ID.
module gray_conv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    gray_conv_arbiter_if.slave bus,
    output logic [WIDTH-1:0]   conv_g,
    input  logic [WIDTH-1:0]   conv_b,
    output logic [COUNT_W-1:0] conv_count,
    output logic [1:0]         state_dbg
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   conv_g_q, conv_g_d;
    logic [WIDTH-1:0]   out_bin_q, out_bin_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               found;
    logic [ID_W-1:0]    winner;
    logic [N_REQ-1:0]   req_ready;
    int                 idx;

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        conv_g_d  = conv_g_q;
        out_bin_d = out_bin_q;
        out_id_d  = out_id_q;
        count_d   = count_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready = rst ? '0 : (N_REQ'(1) << winner);
                    conv_g_d  = bus.req_gray[int'(winner)*WIDTH +: WIDTH];
                    out_id_d  = winner;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                out_bin_d = conv_b;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (out_id_q == ID_W'(N_REQ-1)) ? '0 : out_id_q + ID_W'(1);
                    count_d  = count_q + COUNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            conv_g_q  <= '0;
            out_bin_q <= '0;
            out_id_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            conv_g_q  <= conv_g_d;
            out_bin_q <= out_bin_d;
            out_id_q  <= out_id_d;
            count_q   <= count_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_bin   = out_bin_q;
    assign bus.out_id    = out_id_q;
    assign conv_g        = conv_g_q;
    assign conv_count    = count_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: single transfers, full code table,
// round-robin order, output stall, reset mid-transfer and counter wrap.
module tb_gray_conv_arbiter;
    logic       clk;
    logic       rst;
    logic [3:0] conv_g;
    logic [3:0] conv_b;
    logic [3:0] conv_count;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    logic [3:0] bin_tbl [0:15];
    logic [31:0] exp_q[$];
    logic [31:0] out_q[$];

    gray_conv_arbiter_if #(.N_REQ(4), .WIDTH(4)) bus ();

    gray_conv_arbiter #(.N_REQ(4), .WIDTH(4), .COUNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .conv_g     (conv_g),
        .conv_b     (conv_b),
        .conv_count (conv_count),
        .state_dbg  (state_dbg)
    );

    // Stand-in for the external shared converter.
    always_comb begin
        conv_b = '0;
        for (int i = 0; i < 4; i++) conv_b[i] = ^(conv_g >> i);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_id(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One complete transfer with out_ready raised as soon as the result is valid.
    task automatic do_one(input int id, input logic [3:0] g, input logic [3:0] exp_bin);
        bus.req_valid[id]       = 1'b1;
        bus.req_gray[id*4 +: 4] = g;
        #1;
        check("grant", bus.req_ready, 32'(1) << id);
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
        check("conv_valid_lo", bus.out_valid, 0);
        check("conv_g", conv_g, g);
        @(negedge clk);
        check("out_valid", bus.out_valid, 1);
        check("out_bin", bus.out_bin, exp_bin);
        check("out_id", bus.out_id, id);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_drop", bus.out_valid, 0);
    endtask

    initial begin
        logic [31:0] v;
        int last_grant;
        bin_tbl = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                    4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_gray  = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_bin", bus.out_bin, 0);
        check("rst_out_id", bus.out_id, 0);
        check("rst_conv_g", conv_g, 0);
        check("rst_count", conv_count, 0);
        check("rst_state", state_dbg, 0);
        bus.req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // Single transfer: 0011 -> 0010.
        do_one(0, 4'b0011, 4'b0010);

        // Requester 2 walks every Gray code.
        for (int g = 0; g < 16; g++) do_one(2, 4'(g), bin_tbl[g]);
        check("count_wrap", conv_count, 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // All requesters active: order 0,1,2,3,0 with a grant every 3 cycles.
        exp_q = '{0, 1, 2, 3, 0};
        out_q = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) bus.req_gray[i*4 +: 4] = 4'(i + 4);
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b1;
        last_grant = -3;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (bus.req_ready != 0) begin
                if (exp_q.size() == 0) check("rr_extra_grant", bus.req_ready, 0);
                else check("rr_grant", onehot_id(bus.req_ready), exp_q.pop_front());
                check("rr_gap", c - last_grant, 3);
                last_grant = c;
            end
            if (bus.out_valid) begin
                if (out_q.size() == 0) check("rr_extra_out", bus.out_valid, 0);
                else begin
                    v = out_q.pop_front();
                    check("rr_out_id", bus.out_id, v);
                    check("rr_out_bin", bus.out_bin, bin_tbl[v + 4]);
                end
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        check("rr_grants_left", exp_q.size(), 0);
        check("rr_outs_left", out_q.size(), 0);
        check("rr_count", conv_count, 5);

        // Output stall for 5 cycles while requester 0 waits.
        bus.req_gray[12 +: 4] = 4'd10;
        bus.req_valid = 4'b1000;
        #1;
        check("stall_grant", bus.req_ready, 4'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_valid", bus.out_valid, 1);
            check("stall_bin", bus.out_bin, 12);
            check("stall_id", bus.out_id, 3);
            check("stall_conv_g", conv_g, 10);
            check("stall_req_ready", bus.req_ready, 0);
            check("stall_count", conv_count, 5);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check("release_valid", bus.out_valid, 0);
        check("release_count", conv_count, 6);
        check("waiting_grant", bus.req_ready, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        check("waiting_id", bus.out_id, 0);
        check("waiting_bin", bus.out_bin, bin_tbl[4]);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset during CONV aborts; held request is granted right after release.
        bus.req_gray[4 +: 4] = 4'b0101;
        bus.req_valid = 4'b0010;
        #1;
        check("pre_rst_grant", bus.req_ready, 4'b0010);
        @(negedge clk);
        check("pre_rst_state", state_dbg, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_conv_g", conv_g, 0);
        check("mid_rst_req_ready", bus.req_ready, 0);
        check("mid_rst_count", conv_count, 0);
        check("mid_rst_state", state_dbg, 0);
        rst = 1'b0;
        #1;
        check("post_rst_grant", bus.req_ready, 4'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_id", bus.out_id, 1);
        check("post_rst_bin", bus.out_bin, 4'b0110);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_rst_count", conv_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
